// File: rtl/md_pkg.sv
// Op encodings, FSM state constants and op decode helpers for md_hilo_unit.
// MD_MADD_EN (optional) enables the multiply-accumulate ops 4-7.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;
    localparam logic [2:0] MD_MSUB  = 3'd6;
    localparam logic [2:0] MD_MSUBU = 3'd7;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MUL_WAIT  = 2'd1;
    localparam logic [1:0] DIV_ITER  = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    function automatic logic isDiv(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Even encodings are the signed variants.
    function automatic logic isSigned(input logic [2:0] op);
        return !op[0];
    endfunction

    function automatic logic isMadd(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic isSub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_hilo_unit_if.sv
// Decode-side request/response bundle of the HI/LO multiply/divide unit.
// master = decode stage, slave = md_hilo_unit.
interface md_hilo_unit_if #(
    parameter int XLEN = 32
);

    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            mthi_i;
    logic            mtlo_i;
    logic [XLEN-1:0] wdata_i;
    logic            mfhi_i;
    logic            mflo_i;
    logic [XLEN-1:0] rdata_o;
    logic            stall_o;
    logic            ready_o;
    logic            busy_o;
    logic            done_o;
    logic            div_by_zero_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        output mthi_i, mtlo_i, wdata_i,
        output mfhi_i, mflo_i,
        input  rdata_o, stall_o, ready_o, busy_o,
        input  done_o, div_by_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        input  mthi_i, mtlo_i, wdata_i,
        input  mfhi_i, mflo_i,
        output rdata_o, stall_o, ready_o, busy_o,
        output done_o, div_by_zero_o, hi_o, lo_o
    );

endinterface

// File: rtl/md_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// last is high during the cycle whose edge retires the final bit.
module md_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quoReg;
    logic [XLEN-1:0] remReg;
    logic [XLEN-1:0] dvsReg;
    logic [CW-1:0]   cnt;
    logic            active;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        shifted = {remReg, quoReg[XLEN-1]};
        diff    = shifted - {1'b0, dvsReg};
    end

    assign last      = active && (cnt == CW'(XLEN - 1));
    assign quotient  = quoReg;
    assign remainder = remReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            quoReg <= '0;
            remReg <= '0;
            dvsReg <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            quoReg <= dividend;
            remReg <= '0;
            dvsReg <= divisor;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            // Borrow out of the trial subtract means restore.
            if (diff[XLEN]) begin
                remReg <= shifted[XLEN-1:0];
                quoReg <= {quoReg[XLEN-2:0], 1'b0};
            end else begin
                remReg <= diff[XLEN-1:0];
                quoReg <= {quoReg[XLEN-2:0], 1'b1};
            end
            cnt <= cnt + CW'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/md_hilo_unit.sv
// Multiply/divide unit owning HI/LO, with decode stall and WRITEBACK read bypass.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 4-7).
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 3
) (
    input logic           clk,
    input logic           rst,
    md_hilo_unit_if.slave bus
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [1:0]        state;
    logic [CW-1:0]     mulCnt;
    logic [2:0]        opReg;
    logic [XLEN-1:0]   aReg;
    logic              bSign;
    logic              dbzReg;
    logic [2*XLEN-1:0] prodReg;
    logic [XLEN-1:0]   hiReg;
    logic [XLEN-1:0]   loReg;

    logic              opLegal;
    logic              accept;
    logic              sgn;
    logic              bZero;
    logic              startDiv;
    logic [2*XLEN-1:0] aExt;
    logic [2*XLEN-1:0] bExt;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   divA;
    logic [XLEN-1:0]   divB;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              divLast;
    logic              qNeg;
    logic              rNeg;
    logic [XLEN-1:0]   newHi;
    logic [XLEN-1:0]   newLo;
    logic              reqAny;
    logic              stall;
    logic [XLEN-1:0]   rdata;

    always_comb begin
`ifdef MD_MADD_EN
        opLegal = 1'b1;
`else
        opLegal = !bus.op_i[2];
`endif
        accept   = bus.start_i && (state == IDLE) && opLegal;
        sgn      = isSigned(bus.op_i);
        bZero    = (bus.b_i == '0);
        startDiv = accept && isDiv(bus.op_i) && !bZero;
        aExt     = {{XLEN{sgn & bus.a_i[XLEN-1]}}, bus.a_i};
        bExt     = {{XLEN{sgn & bus.b_i[XLEN-1]}}, bus.b_i};
        product  = aExt * bExt;
        divA     = (sgn && bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
        divB     = (sgn && bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;
    end

    md_div_iter #(
        .XLEN(XLEN)
    ) uDiv (
        .clk      (clk),
        .rst      (rst),
        .load     (startDiv),
        .dividend (divA),
        .divisor  (divB),
        .quotient (quo),
        .remainder(rem),
        .last     (divLast)
    );

    // Result presented during WRITEBACK; also the read-bypass source.
    always_comb begin
        qNeg           = isSigned(opReg) && (aReg[XLEN-1] ^ bSign);
        rNeg           = isSigned(opReg) && aReg[XLEN-1];
        {newHi, newLo} = prodReg;
`ifdef MD_MADD_EN
        if (isMadd(opReg)) begin
            if (isSub(opReg)) begin
                {newHi, newLo} = {hiReg, loReg} - prodReg;
            end else begin
                {newHi, newLo} = {hiReg, loReg} + prodReg;
            end
        end
`endif
        if (dbzReg) begin
            newHi = aReg;
            newLo = '1;
        end else if (isDiv(opReg)) begin
            newHi = rNeg ? -rem : rem;
            newLo = qNeg ? -quo : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mulCnt  <= '0;
            opReg   <= '0;
            aReg    <= '0;
            bSign   <= 1'b0;
            dbzReg  <= 1'b0;
            prodReg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        opReg   <= bus.op_i;
                        aReg    <= bus.a_i;
                        bSign   <= bus.b_i[XLEN-1];
                        prodReg <= product;
                        mulCnt  <= '0;
                        dbzReg  <= isDiv(bus.op_i) && bZero;
                        if (isDiv(bus.op_i)) begin
                            state <= bZero ? WRITEBACK : DIV_ITER;
                        end else begin
                            state <= (MUL_CYCLES == 1) ? WRITEBACK : MUL_WAIT;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (mulCnt == CW'(MUL_CYCLES - 2)) begin
                        state <= WRITEBACK;
                    end else begin
                        mulCnt <= mulCnt + CW'(1);
                    end
                end
                DIV_ITER: begin
                    if (divLast) begin
                        state <= WRITEBACK;
                    end
                end
                WRITEBACK: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // mthi/mtlo seen in WRITEBACK are stalled and land once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (state == WRITEBACK) begin
            hiReg <= newHi;
            loReg <= newLo;
        end else if (state == IDLE) begin
            if (bus.mthi_i) begin
                hiReg <= bus.wdata_i;
            end
            if (bus.mtlo_i) begin
                loReg <= bus.wdata_i;
            end
        end
    end

    always_comb begin
        reqAny = bus.start_i | bus.mthi_i | bus.mtlo_i
               | bus.mfhi_i | bus.mflo_i;
        stall = 1'b0;
        case (state)
            MUL_WAIT:  stall = reqAny;
            DIV_ITER:  stall = reqAny;
            WRITEBACK: stall = bus.start_i | bus.mthi_i | bus.mtlo_i;
            default:   stall = 1'b0;
        endcase
        rdata = '0;
        if (!stall && state == IDLE) begin
            if (bus.mfhi_i) begin
                rdata = hiReg;
            end else if (bus.mflo_i) begin
                rdata = loReg;
            end
        end else if (!stall && state == WRITEBACK) begin
            if (bus.mfhi_i) begin
                rdata = newHi;
            end else if (bus.mflo_i) begin
                rdata = newLo;
            end
        end
    end

    assign bus.rdata_o       = rdata;
    assign bus.stall_o       = stall;
    assign bus.ready_o       = (state == IDLE);
    assign bus.busy_o        = (state != IDLE);
    assign bus.done_o        = (state == WRITEBACK);
    assign bus.div_by_zero_o = (state == WRITEBACK) && dbzReg;
    assign bus.hi_o          = hiReg;
    assign bus.lo_o          = loReg;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed bench for md_hilo_unit (XLEN=32, MUL_CYCLES=3).
// Expectations for ops 4-7 follow whether MD_MADD_EN is defined.
module tb_md_hilo_unit;
    import md_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    md_hilo_unit_if #(.XLEN(32)) bus ();

    md_hilo_unit #(
        .XLEN      (32),
        .MUL_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operands, wait (bounded) for done_o.
    task automatic runOp(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int lat);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        step();
        bus.start_i = 1'b0;
        bus.a_i     = 32'hDEADBEEF;
        bus.b_i     = 32'h12345678;
        lat = 1;
        while (!bus.done_o && lat < 100) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dn;
        total = 0;
        bad   = 0;
        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
        bus.wdata_i = '0;
        bus.mfhi_i  = 1'b0;
        bus.mflo_i  = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_dbz", bus.div_by_zero_o, 0);
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);

        // MULT -2*3 with an early mflo and a second start while busy
        bus.start_i = 1'b1;
        bus.op_i    = MD_MULT;
        bus.a_i     = 32'hFFFFFFFE;
        bus.b_i     = 32'd3;
        #1;
        chk("mul_idle_stall", bus.stall_o, 0);
        step();
        bus.op_i   = MD_DIVU;
        bus.a_i    = 32'd100;
        bus.b_i    = 32'd7;
        bus.mflo_i = 1'b1;
        #1;
        chk("mul_c1_busy", bus.busy_o, 1);
        chk("mul_c1_stall", bus.stall_o, 1);
        chk("mul_c1_rdata", bus.rdata_o, 0);
        chk("mul_c1_done", bus.done_o, 0);
        step();
        bus.start_i = 1'b0;
        #1;
        chk("mul_c2_stall", bus.stall_o, 1);
        chk("mul_c2_done", bus.done_o, 0);
        step();
        chk("mul_c3_done", bus.done_o, 1);
        chk("mul_wb_stall", bus.stall_o, 0);
        chk("mul_wb_bypass", bus.rdata_o, 32'hFFFFFFFA);
        chk("mul_wb_lo_old", bus.lo_o, 0);
        step();
        bus.mflo_i = 1'b0;
        chk("mul_ready", bus.ready_o, 1);
        chk("mul_hi", bus.hi_o, 32'hFFFFFFFF);
        chk("mul_lo", bus.lo_o, 32'hFFFFFFFA);

        runOp(MD_DIVU, 32'd100, 32'd7, lat);
        chk("divu_lat", lat, 33);
        chk("divu_dbz", bus.div_by_zero_o, 0);
        step();
        chk("divu_lo", bus.lo_o, 32'd14);
        chk("divu_hi", bus.hi_o, 32'd2);

        runOp(MD_DIV, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_lat", lat, 33);
        step();
        chk("div_lo", bus.lo_o, 32'hFFFFFFFD);
        chk("div_hi", bus.hi_o, 32'hFFFFFFFF);

        runOp(MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        step();
        chk("divmin_lo", bus.lo_o, 32'h80000000);
        chk("divmin_hi", bus.hi_o, 0);

        runOp(MD_DIV, 32'd5, 32'd0, lat);
        chk("dbz_lat", lat, 1);
        chk("dbz_flag", bus.div_by_zero_o, 1);
        step();
        chk("dbz_hi", bus.hi_o, 32'd5);
        chk("dbz_lo", bus.lo_o, 32'hFFFFFFFF);
        chk("dbz_clr", bus.div_by_zero_o, 0);

        runOp(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("multu_lat", lat, 3);
        step();
        chk("multu_hi", bus.hi_o, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo_o, 32'd1);

        // reset during divide iteration 10
        bus.start_i = 1'b1;
        bus.op_i    = MD_DIVU;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        step();
        bus.start_i = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        chk("abort_ready", bus.ready_o, 1);
        chk("abort_hi", bus.hi_o, 0);
        chk("abort_lo", bus.lo_o, 0);
        chk("abort_done", bus.done_o, 0);
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done_o) dn++;
        end
        chk("abort_no_done", dn, 0);

        // mthi in IDLE; same-cycle mfhi sees old HI
        bus.mthi_i  = 1'b1;
        bus.mfhi_i  = 1'b1;
        bus.wdata_i = 32'h0000ABCD;
        #1;
        chk("mthi_old_read", bus.rdata_o, 0);
        chk("mthi_stall", bus.stall_o, 0);
        step();
        bus.mthi_i = 1'b0;
        #1;
        chk("mthi_hi", bus.hi_o, 32'h0000ABCD);
        chk("mthi_read", bus.rdata_o, 32'h0000ABCD);
        bus.mfhi_i = 1'b0;

        // mtlo during WRITEBACK is deferred
        runOp(MD_MULT, 32'd2, 32'd3, lat);
        bus.mtlo_i  = 1'b1;
        bus.wdata_i = 32'h55;
        #1;
        chk("wb_mtlo_stall", bus.stall_o, 1);
        step();
        chk("wb_mtlo_res_lo", bus.lo_o, 32'd6);
        chk("wb_mtlo_res_hi", bus.hi_o, 0);
        chk("wb_mtlo_idle", bus.stall_o, 0);
        step();
        bus.mtlo_i = 1'b0;
        chk("wb_mtlo_lo", bus.lo_o, 32'h55);

        // HI=0, LO=all ones, then MADDU 1*1
        bus.mthi_i  = 1'b1;
        bus.wdata_i = 32'd0;
        step();
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b1;
        bus.wdata_i = 32'hFFFFFFFF;
        step();
        bus.mtlo_i = 1'b0;
`ifdef MD_MADD_EN
        runOp(MD_MADDU, 32'd1, 32'd1, lat);
        chk("madd_lat", lat, 3);
        step();
        chk("madd_hi", bus.hi_o, 32'd1);
        chk("madd_lo", bus.lo_o, 32'd0);
`else
        bus.start_i = 1'b1;
        bus.op_i    = MD_MADDU;
        bus.a_i     = 32'd1;
        bus.b_i     = 32'd1;
        #1;
        chk("madd_off_stall", bus.stall_o, 0);
        step();
        bus.start_i = 1'b0;
        chk("madd_off_ready", bus.ready_o, 1);
        chk("madd_off_done", bus.done_o, 0);
        step();
        step();
        chk("madd_off_done2", bus.done_o, 0);
        chk("madd_off_hi", bus.hi_o, 32'd0);
        chk("madd_off_lo", bus.lo_o, 32'hFFFFFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
